vec_lane_collector: RTL

- Issue-and-gather controller on the core side of the 4-lane vector ALU array.
- On a start request it raises per-lane run for each active lane.
- Lanes return 64-bit result chunks tagged with a destination bit offset; the block writes each chunk into a VLEN-bit destination register image.
- Once every chunk is covered, it presents the assembled vector to the register-file writeback through a valid/ready handshake.

---
 rtl/vec_lane_collector.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vec_lane_collector.sv
// Issue-and-gather controller for the 4-lane vector ALU array: runs the active
// lanes, assembles their 64-bit result chunks into a VLEN-bit image, then hands it off.
module vec_lane_collector #(
   parameter int unsigned VLEN    = 128,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [1:0]      nb_lanes,
   input  logic            start,
   output logic            run0,
   output logic            run1,
   output logic            run2,
   output logic            run3,
   input  logic [63:0]     vd0,
   input  logic [63:0]     vd1,
   input  logic [63:0]     vd2,
   input  logic [63:0]     vd3,
   input  logic [9:0]      regi0,
   input  logic [9:0]      regi1,
   input  logic [9:0]      regi2,
   input  logic [9:0]      regi3,
   input  logic            done0,
   input  logic            done1,
   input  logic            done2,
   input  logic            done3,
   output logic            busy,
   output logic [VLEN-1:0] result,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [1:0]      err
);

   localparam int unsigned NCHUNK = VLEN / 64;

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        nb_q, nb_d;
   logic [NCHUNK-1:0] mask_q, mask_d;
   logic [NCHUNK-1:0] hit;
   logic [VLEN-1:0]   result_q, result_d;
   logic [1:0]        err_q, err_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              any_done;

   logic [63:0] vd_a   [4];
   logic [9:0]  regi_a [4];
   logic [3:0]  done_v;
   logic [3:0]  run_v;

   assign vd_a[0]   = vd0;
   assign vd_a[1]   = vd1;
   assign vd_a[2]   = vd2;
   assign vd_a[3]   = vd3;
   assign regi_a[0] = regi0;
   assign regi_a[1] = regi1;
   assign regi_a[2] = regi2;
   assign regi_a[3] = regi3;
   assign done_v    = {done3, done2, done1, done0};

   always_comb begin
      state_d  = state_q;
      nb_d     = nb_q;
      mask_d   = mask_q;
      result_d = result_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      hit      = '0;
      any_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               nb_d     = nb_lanes;
               mask_d   = '0;
               result_d = '0;
               err_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // Lanes are visited in ascending order so that on a same-cycle
            // collision the lowest-numbered lane claims the chunk first.
            for (int k = 0; k < 4; k++) begin
               if (done_v[k] && (2'(k) <= nb_q)) begin
                  any_done = 1'b1;
                  if ((regi_a[k][5:0] != 6'd0) || (32'(regi_a[k]) >= VLEN)) begin
                     err_d[0] = 1'b1;
                  end else begin
                     for (int c = 0; c < int'(NCHUNK); c++) begin
                        if (regi_a[k][9:6] == 4'(c)) begin
                           if (hit[c]) begin
                              err_d[0] = 1'b1;
                           end else begin
                              result_d[c*64 +: 64] = vd_a[k];
                              if (mask_q[c]) err_d[0] = 1'b1;
                              mask_d[c] = 1'b1;
                              hit[c]    = 1'b1;
                           end
                        end
                     end
                  end
               end
            end
            cnt_d = any_done ? 16'd0 : cnt_q + 16'd1;
            if (&mask_d) begin
               state_d = RESP;
            end else if (!any_done && (cnt_d == 16'(TIMEOUT - 1))) begin
               err_d[1] = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         run_v[k] = (state_q == RUN) && (2'(k) <= nb_q);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         nb_q     <= '0;
         mask_q   <= '0;
         result_q <= '0;
         err_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         nb_q     <= nb_d;
         mask_q   <= mask_d;
         result_q <= result_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign run0         = run_v[0];
   assign run1         = run_v[1];
   assign run2         = run_v[2];
   assign run3         = run_v[3];
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == RESP);
   assign result       = result_q;
   assign err          = err_q;

endmodule
